msk_share_encoder: RTL and testbench
====================================

# msk_share_encoder

Streaming masked-sharing encoder: turns unmasked W-bit words into d-share Boolean sharings that masked gadget pipelines (HPC2/HPC3 ANDs, XORs, refreshes) can consume. It sits at the boundary between the unmasked host datapath and the masked core, the producer side of the sharing interface those gadgets consume. It consumes fresh randomness through its own handshake and registers every output share, so no combinational recombination path leaves the block. It also keeps word and randomness-starvation counters for the testbench and debug.

## Interface
- d, 2, number of shares; d >= 2 required (elaboration error otherwise).
- W, 8, bits per unmasked word.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  W  unmasked word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- rnd  input  (d-1)*W  fresh random bits; bits [(j-1)*W +: W] form share j.
- rnd_valid  input  1  rnd valid.
- rnd_ready  output  1  rnd consumed this cycle when rnd_valid && rnd_ready.
- out_shares  output  d*W  sharing, bit-major: bit i occupies [d*i +: d], share j of bit i at index d*i+j.
- out_valid  output  1  out_shares holds a sharing.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- words_out  output  32  count of sharings delivered downstream.
- rnd_stall_cnt  output  16  cycles lost waiting for randomness.

## Operation
- Output stage is one register slot (out_shares, out_valid).
- space = !out_valid || out_ready.
- fire = in_valid && rnd_valid && space.
- in_ready = rnd_valid && space; rnd_ready = in_valid && space. Randomness is never consumed without a word, and a word is never consumed without randomness.
- On fire: for every bit i, share j (1..d-1) = rnd[(j-1)*W + i]; share 0 = in_data[i] XOR (XOR over j of those rnd bits). Shares are computed combinationally and captured in the register; only registered values drive out_shares.
- State: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY, fire: FULL.
  - FULL, out_ready && !fire: EMPTY.
  - FULL, out_ready && fire: stays FULL with the new sharing (back-to-back).
  - FULL, !out_ready: hold out_shares bit-stable; no fire possible.
- On out_valid && out_ready: words_out += 1, wrapping modulo 2^32.
- rnd_stall_cnt += 1 on each cycle with in_valid && !rnd_valid && space. Saturates at 0xFFFF.
- When no fire occurs, out_shares keeps its last value. It is never cleared to expose in_data.
- Unmasked in_data never reaches any output or register unmixed with randomness.

## Timing
- Reset values: out_valid=0, out_shares=0, words_out=0, rnd_stall_cnt=0. in_ready and rnd_ready follow their formulas, so after reset each equals the other channel's valid.
- Latency: a word accepted on edge k is visible with out_valid=1 after edge k, so it is visible in cycle k+1.
- Throughput: one sharing per cycle while in_valid, rnd_valid and out_ready are all high.
- Simultaneous drain and fire: no bubble; words_out increments and the new sharing loads on the same edge.
- rst asserted mid-operation: the held sharing is dropped and the counters clear on that edge. No handshake completes in a cycle where rst=1; in_ready and rnd_ready are forced low.
- Randomness consumption: exactly (d-1)*W bits per encoded word.

## Test plan
- d=2, W=8, in_data=0xA5, rnd=0x3C, both valid, out_ready=1 -> one cycle later out_valid=1, share1 bits=0x3C, share0 bits=0x99, recombination=0xA5, words_out=1 after the following edge.
- Backpressure: out_ready=0 for 5 cycles with a new word and rnd pending -> out_shares stable, in_ready=rnd_ready=0, no rnd consumed. Release -> next word loads on the same edge as the drain, no bubble.
- Starvation: in_valid=1 and rnd_valid=0 for 70000 cycles, output empty -> rnd_stall_cnt=0xFFFF (saturated), in_ready=0, out_valid stays 0.
- d=3, W=8, in_data=0xFF, rnd share1=0x0F, share2=0xF0 -> share0=0x00 and recombination=0xFF. Then a random 1000-word stream with random valid/ready gaps -> every recombined output equals its input in order, and words_out=1000.
- Reset while FULL and out_ready=0 -> next cycle out_valid=0, out_shares=0, both counters 0, and the held word is never delivered.

Source files
------------

// File: rtl/msk_share_encoder_if.sv
// rtl/msk_share_encoder_if.sv - handshake bundle between host/randomness sources and the share encoder
interface msk_share_encoder_if #(
  parameter int d = 2,
  parameter int W = 8
);
  // unmasked word channel
  logic [W-1:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  // fresh randomness channel, share j in bits [(j-1)*W +: W]
  logic [(d-1)*W-1:0] rnd;
  logic               rnd_valid;
  logic               rnd_ready;
  // registered sharing, bit-major: share j of bit i at index d*i+j
  logic [d*W-1:0]     out_shares;
  logic               out_valid;
  logic               out_ready;
  // debug counters
  logic [31:0]        words_out;
  logic [15:0]        rnd_stall_cnt;

  modport master (
    output in_data, in_valid, rnd, rnd_valid, out_ready,
    input  in_ready, rnd_ready, out_shares, out_valid, words_out, rnd_stall_cnt
  );

  modport slave (
    input  in_data, in_valid, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_shares, out_valid, words_out, rnd_stall_cnt
  );
endinterface

// File: rtl/msk_share_encoder.sv
// rtl/msk_share_encoder.sv - streaming Boolean masked-sharing encoder with registered share output
module msk_share_encoder #(
  parameter int d = 2,
  parameter int W = 8
) (
  input logic                clk,
  input logic                rst,
  msk_share_encoder_if.slave bus
);

  if (d < 2) begin : g_bad_share_count
    $error("msk_share_encoder: d must be at least 2");
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic           out_valid_q;
  logic [d*W-1:0] shares_q;
  logic [31:0]    words_q;
  logic [15:0]    stall_q;

  logic           space;
  logic           fire;
  logic           drain;
  logic           starved;
  logic [d*W-1:0] shares_d;

  // The output slot can take a new sharing when empty or being drained this cycle.
  // Handshakes are gated by rst so nothing completes on a reset edge.
  assign space   = !out_valid_q || bus.out_ready;
  assign fire    = !rst && bus.in_valid && bus.rnd_valid && space;
  assign drain   = !rst && out_valid_q && bus.out_ready;
  assign starved = bus.in_valid && !bus.rnd_valid && space;

  // A word and its randomness are only ever taken together.
  assign bus.in_ready  = !rst && bus.rnd_valid && space;
  assign bus.rnd_ready = !rst && bus.in_valid && space;

  // Share j (j>=1) of each bit is the raw random bit; share 0 absorbs the data bit
  // XORed with all random bits, so recombination over all shares yields the data.
  // This value only ever feeds the share register, never an output directly.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic [d-2:0] r_bits;
    for (genvar j = 1; j < d; j++) begin : g_share
      assign r_bits[j-1]         = bus.rnd[(j-1)*W+i];
      assign shares_d[d*i+j]     = bus.rnd[(j-1)*W+i];
    end
    assign shares_d[d*i] = bus.in_data[i] ^ (^r_bits);
  end

  // Output slot FSM: loads on fire, empties on drain without refill, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      shares_q    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (fire) begin
            state       <= FULL;
            out_valid_q <= 1'b1;
            shares_q    <= shares_d;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            if (fire) begin
              shares_q <= shares_d;
            end else begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Delivered-word counter wraps; starvation counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (drain) begin
        words_q <= words_q + 32'd1;
      end
      if (starved && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign bus.out_shares    = shares_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.words_out     = words_q;
  assign bus.rnd_stall_cnt = stall_q;

endmodule

// File: tb/tb_msk_share_encoder.sv
// tb/tb_msk_share_encoder.sv - scoreboard bench for msk_share_encoder with d=2 and d=3 instances
module tb_msk_share_encoder;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  msk_share_encoder_if #(.d(2), .W(8)) a_if ();
  msk_share_encoder_if #(.d(3), .W(8)) b_if ();

  msk_share_encoder #(.d(2), .W(8)) u_a (.clk(clk), .rst(rst_a), .bus(a_if));
  msk_share_encoder #(.d(3), .W(8)) u_b (.clk(clk), .rst(rst_b), .bus(b_if));

  int total = 0;
  int bad   = 0;

  logic [23:0] sb_a[$];
  logic [7:0]  dq_a[$];
  logic [23:0] sb_b[$];
  logic [7:0]  dq_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference sharing: share words first, then laid out bit-major.
  function automatic logic [23:0] model(input int dd, input logic [7:0] data, input logic [15:0] r);
    logic [7:0]  sw[3];
    logic [23:0] v;
    sw[0] = data;
    for (int j = 1; j < dd; j++) begin
      sw[j] = r[(j-1)*8 +: 8];
      sw[0] = sw[0] ^ sw[j];
    end
    v = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < dd; j++)
        v[dd*i+j] = sw[j][i];
    return v;
  endfunction

  function automatic logic [7:0] get_share(input logic [23:0] v, input int dd, input int j);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = v[dd*i+j];
    return s;
  endfunction

  function automatic logic [7:0] recomb(input logic [23:0] v, input int dd);
    logic [7:0] x = 8'h00;
    for (int j = 0; j < dd; j++) x = x ^ get_share(v, dd, j);
    return x;
  endfunction

  logic [23:0] exp_a, exp_b;
  logic [7:0]  dat_a, dat_b;

  // Monitor and stimulus recorder for the d=2 instance.
  always @(negedge clk) begin
    if (!rst_a && a_if.out_valid && a_if.out_ready) begin
      chk("a_sb_nonempty", 32'(sb_a.size() > 0), 32'd1);
      if (sb_a.size() > 0) begin
        exp_a = sb_a.pop_front();
        dat_a = dq_a.pop_front();
        chk("a_shares", 32'(a_if.out_shares), 32'(exp_a[15:0]));
        chk("a_recomb", 32'(recomb({8'h00, a_if.out_shares}, 2)), 32'(dat_a));
      end
    end
    if (!rst_a && a_if.in_valid && a_if.in_ready) begin
      sb_a.push_back(model(2, a_if.in_data, {8'h00, a_if.rnd}));
      dq_a.push_back(a_if.in_data);
    end
  end

  // Monitor and stimulus recorder for the d=3 instance.
  always @(negedge clk) begin
    if (!rst_b && b_if.out_valid && b_if.out_ready) begin
      chk("b_sb_nonempty", 32'(sb_b.size() > 0), 32'd1);
      if (sb_b.size() > 0) begin
        exp_b = sb_b.pop_front();
        dat_b = dq_b.pop_front();
        chk("b_shares", 32'(b_if.out_shares), 32'(exp_b));
        chk("b_recomb", 32'(recomb(b_if.out_shares, 3)), 32'(dat_b));
      end
    end
    if (!rst_b && b_if.in_valid && b_if.in_ready) begin
      sb_b.push_back(model(3, b_if.in_data, b_if.rnd));
      dq_b.push_back(b_if.in_data);
    end
  end

  task automatic test_a();
    logic [7:0] xd, xr, yd, yr;
    // single word A5 / 3C
    @(posedge clk); #1;
    a_if.in_data = 8'hA5; a_if.rnd = 8'h3C;
    a_if.in_valid = 1'b1; a_if.rnd_valid = 1'b1; a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0; a_if.rnd_valid = 1'b0;
    @(negedge clk);
    chk("a1_out_valid", 32'(a_if.out_valid), 32'd1);
    chk("a1_share1", 32'(get_share({8'h00, a_if.out_shares}, 2, 1)), 32'h3C);
    chk("a1_share0", 32'(get_share({8'h00, a_if.out_shares}, 2, 0)), 32'h99);
    chk("a1_words_before", a_if.words_out, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("a1_words_after", a_if.words_out, 32'd1);
    chk("a1_out_valid_drained", 32'(a_if.out_valid), 32'd0);

    // backpressure: X held while Y waits
    @(posedge clk); #1;
    xd = 8'($urandom); xr = 8'($urandom);
    a_if.in_data = xd; a_if.rnd = xr;
    a_if.in_valid = 1'b1; a_if.rnd_valid = 1'b1; a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    yd = 8'($urandom); yr = 8'($urandom);
    a_if.in_data = yd; a_if.rnd = yr; a_if.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(a_if.out_valid), 32'd1);
      chk("bp_stable", 32'(a_if.out_shares), 32'(model(2, xd, {8'h00, xr})));
      chk("bp_in_ready", 32'(a_if.in_ready), 32'd0);
      chk("bp_rnd_ready", 32'(a_if.rnd_ready), 32'd0);
      @(posedge clk); #1;
    end
    a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(a_if.in_ready), 32'd1);
    @(posedge clk); #1;
    a_if.in_valid = 1'b0; a_if.rnd_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_bubble", 32'(a_if.out_valid), 32'd1);
    chk("bp_y_loaded", 32'(a_if.out_shares), 32'(model(2, yd, {8'h00, yr})));
    chk("bp_words", a_if.words_out, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_words_final", a_if.words_out, 32'd3);

    // reset while FULL and stalled
    @(posedge clk); #1;
    a_if.in_data = 8'($urandom); a_if.rnd = 8'($urandom);
    a_if.in_valid = 1'b1; a_if.rnd_valid = 1'b1; a_if.out_ready = 1'b0;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0; a_if.rnd_valid = 1'b0;
    @(negedge clk);
    chk("rs_full_before", 32'(a_if.out_valid), 32'd1);
    @(posedge clk); #1;
    rst_a = 1'b1;
    sb_a.delete(); dq_a.delete();
    @(posedge clk); #1;
    rst_a = 1'b0; a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("rs_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rs_out_shares", 32'(a_if.out_shares), 32'd0);
    chk("rs_words", a_if.words_out, 32'd0);
    chk("rs_stall", 32'(a_if.rnd_stall_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rs_never_delivered", 32'(a_if.words_out), 32'd0);

    // randomness starvation with an empty output
    @(posedge clk); #1;
    a_if.in_valid = 1'b1; a_if.rnd_valid = 1'b0; a_if.out_ready = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("st_count_100", 32'(a_if.rnd_stall_cnt), 32'd100);
    repeat (65500) @(posedge clk);
    @(negedge clk);
    chk("st_saturated", 32'(a_if.rnd_stall_cnt), 32'hFFFF);
    chk("st_in_ready", 32'(a_if.in_ready), 32'd0);
    chk("st_rnd_ready", 32'(a_if.rnd_ready), 32'd1);
    chk("st_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("st_words", a_if.words_out, 32'd0);
    a_if.in_valid = 1'b0;
  endtask

  task automatic test_b();
    int sent;
    int cyc;
    // directed d=3 word FF with shares 0F / F0
    @(posedge clk); #1;
    b_if.in_data = 8'hFF; b_if.rnd = {8'hF0, 8'h0F};
    b_if.in_valid = 1'b1; b_if.rnd_valid = 1'b1; b_if.out_ready = 1'b1;
    @(posedge clk); #1;
    b_if.in_valid = 1'b0; b_if.rnd_valid = 1'b0;
    @(negedge clk);
    chk("b1_share0", 32'(get_share(b_if.out_shares, 3, 0)), 32'h00);
    chk("b1_share1", 32'(get_share(b_if.out_shares, 3, 1)), 32'h0F);
    chk("b1_share2", 32'(get_share(b_if.out_shares, 3, 2)), 32'hF0);
    chk("b1_recomb", 32'(recomb(b_if.out_shares, 3)), 32'hFF);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_rst_words", b_if.words_out, 32'd0);

    // random 1000-word stream with random valid/ready gaps
    sent = 0; cyc = 0;
    @(posedge clk); #1;
    while (sent < 1000 && cyc < 20000) begin
      b_if.in_data   = 8'($urandom);
      b_if.rnd       = 16'($urandom);
      b_if.in_valid  = ($urandom_range(0, 3) != 0);
      b_if.rnd_valid = ($urandom_range(0, 3) != 0);
      b_if.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b_if.in_valid && b_if.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("b_stream_sent", 32'(sent), 32'd1000);
    b_if.in_valid = 1'b0; b_if.rnd_valid = 1'b0; b_if.out_ready = 1'b1;
    cyc = 0;
    while (sb_b.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    @(negedge clk);
    chk("b_drain_empty", 32'(sb_b.size()), 32'd0);
    chk("b_words_out", b_if.words_out, 32'd1000);
    chk("b_out_valid_idle", 32'(b_if.out_valid), 32'd0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_if.in_data = '0; a_if.rnd = '0; a_if.in_valid = 1'b0; a_if.rnd_valid = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_data = '0; b_if.rnd = '0; b_if.in_valid = 1'b0; b_if.rnd_valid = 1'b0; b_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_if.in_valid = 1'b1; a_if.rnd_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_forced", 32'(a_if.in_ready), 32'd0);
    chk("rst_rnd_ready_forced", 32'(a_if.rnd_ready), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("reset_out_shares", 32'(a_if.out_shares), 32'd0);
    chk("reset_words", a_if.words_out, 32'd0);
    chk("reset_stall", 32'(a_if.rnd_stall_cnt), 32'd0);
    chk("reset_in_ready", 32'(a_if.in_ready), 32'd1);
    chk("reset_rnd_ready", 32'(a_if.rnd_ready), 32'd0);
    @(posedge clk); #1;
    a_if.rnd_valid = 1'b0;
    fork
      test_a();
      test_b();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
